// File: rtl/cotm32_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cotm32_pkg
//  Description : Shared core types; load/store operation encoding.
//  Revision    : 1.0  initial release
// ============================================================================
package cotm32_pkg;

    typedef enum logic [3:0] {
        LSU_NONE = 4'd0,
        LSU_LB   = 4'd1,
        LSU_LH   = 4'd2,
        LSU_LW   = 4'd3,
        LSU_LBU  = 4'd4,
        LSU_LHU  = 4'd5,
        LSU_SB   = 4'd6,
        LSU_SH   = 4'd7,
        LSU_SW   = 4'd8
    } ls_op_e;

endpackage
`default_nettype wire

// File: rtl/mem_lsu_if.sv
`default_nettype none
// ============================================================================
//  Module      : mem_lsu_if
//  Description : Data-memory request/response bus between LSU and memory.
//                Signal directions are named from the LSU side.
//  Revision    : 1.0  initial release
// ============================================================================
interface mem_lsu_if;

    logic        o_dmem_req;
    logic        o_dmem_we;
    logic [31:0] o_dmem_addr;
    logic [3:0]  o_dmem_be;
    logic [31:0] o_dmem_wdata;
    logic        i_dmem_gnt;
    logic        i_dmem_rvalid;
    logic [31:0] i_dmem_rdata;
    logic        i_dmem_err;

    modport master (
        output o_dmem_req, o_dmem_we, o_dmem_addr, o_dmem_be, o_dmem_wdata,
        input  i_dmem_gnt, i_dmem_rvalid, i_dmem_rdata, i_dmem_err
    );

    modport slave (
        input  o_dmem_req, o_dmem_we, o_dmem_addr, o_dmem_be, o_dmem_wdata,
        output i_dmem_gnt, i_dmem_rvalid, i_dmem_rdata, i_dmem_err
    );

endinterface
`default_nettype wire

// File: rtl/mem_lsu.sv
`default_nettype none
// ============================================================================
//  Module      : mem_lsu
//  Description : Load/store unit. Aligns and issues one data-memory access per
//                op, waits for the response (with timeout), extends load data
//                and reports misalignment/access-fault traps.
//  Revision    : 1.0  initial release
// ============================================================================
module mem_lsu
    import cotm32_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  wire logic        i_clk,
    input  wire logic        i_rst_n,
    input  wire logic        i_valid,
    input  ls_op_e           i_ls_op,
    input  wire logic [31:0] i_addr,
    input  wire logic [31:0] i_wdata,
    input  wire logic        i_flush,
    output logic             o_stall,
    output logic             o_done,
    output logic [31:0]      o_rdata,
    output logic             o_t_load_misaligned,
    output logic             o_t_store_misaligned,
    output logic             o_t_load_fault,
    output logic             o_t_store_fault,
    mem_lsu_if.master        dmem
);

    // Last WAIT count value before the access is declared faulted.
    localparam logic [7:0] c_TO_LAST = 8'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_RESP = 2'd3
    } state_e;

    state_e      r_state, w_next;
    ls_op_e      r_op;
    logic [31:0] r_addr, r_wdata, r_rdata;
    logic [3:0]  r_be;
    logic [7:0]  r_cnt;
    logic        r_kill, r_mis, r_fault;

    logic        w_mem_op, w_mis, w_ld, w_set_kill, w_end_wait, w_timeout;
    logic        w_r_load, w_r_store;
    logic [3:0]  w_be_in;
    logic [31:0] w_wd_in, w_lane, w_ext;

    // Decode the incoming op: alignment, lane enables and replicated store data.
    always_comb begin
        w_mem_op = i_valid && (i_ls_op != LSU_NONE);
        w_mis    = 1'b0;
        w_be_in  = 4'b1111;
        w_wd_in  = 32'd0;
        case (i_ls_op)
            LSU_LB, LSU_LBU: w_be_in = 4'b0001 << i_addr[1:0];
            LSU_SB: begin
                w_be_in = 4'b0001 << i_addr[1:0];
                w_wd_in = {4{i_wdata[7:0]}};
            end
            LSU_LH, LSU_LHU: begin
                w_mis   = i_addr[0];
                w_be_in = i_addr[1] ? 4'b1100 : 4'b0011;
            end
            LSU_SH: begin
                w_mis   = i_addr[0];
                w_be_in = i_addr[1] ? 4'b1100 : 4'b0011;
                w_wd_in = {2{i_wdata[15:0]}};
            end
            LSU_LW: w_mis = (i_addr[1:0] != 2'b00);
            LSU_SW: begin
                w_mis   = (i_addr[1:0] != 2'b00);
                w_wd_in = i_wdata;
            end
            default: ;
        endcase
    end

    // Next-state logic and all outputs derived from the latched op.
    always_comb begin
        w_next     = r_state;
        w_ld       = 1'b0;
        w_set_kill = 1'b0;
        w_end_wait = 1'b0;
        w_timeout  = 1'b0;
        w_r_load   = r_op inside {LSU_LB, LSU_LH, LSU_LW, LSU_LBU, LSU_LHU};
        w_r_store  = r_op inside {LSU_SB, LSU_SH, LSU_SW};
        o_stall    = 1'b0;
        case (r_state)
            S_IDLE: begin
                o_stall = w_mem_op && i_rst_n;
                if (w_mem_op) begin
                    w_ld   = 1'b1;
                    w_next = w_mis ? S_RESP : S_REQ;
                end
            end
            S_REQ: begin
                o_stall = 1'b1;
                if (dmem.i_dmem_gnt) begin
                    w_next     = S_WAIT;
                    w_set_kill = i_flush;
                end else if (i_flush) begin
                    w_next = S_IDLE;
                end
            end
            S_WAIT: begin
                o_stall = 1'b1;
                if (dmem.i_dmem_rvalid || (r_cnt == c_TO_LAST)) begin
                    w_end_wait = 1'b1;
                    w_timeout  = !dmem.i_dmem_rvalid;
                    // A killed access drains silently once the bus answers.
                    w_next     = (r_kill || i_flush) ? S_IDLE : S_RESP;
                end else begin
                    w_set_kill = i_flush;
                end
            end
            S_RESP:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase

        w_lane = r_rdata >> {r_addr[1:0], 3'b000};
        case (r_op)
            LSU_LB:  w_ext = {{24{w_lane[7]}}, w_lane[7:0]};
            LSU_LBU: w_ext = {24'd0, w_lane[7:0]};
            LSU_LH:  w_ext = {{16{w_lane[15]}}, w_lane[15:0]};
            LSU_LHU: w_ext = {16'd0, w_lane[15:0]};
            LSU_LW:  w_ext = w_lane;
            default: w_ext = 32'd0;
        endcase

        o_done               = (r_state == S_RESP) && !i_flush;
        o_rdata              = (o_done && w_r_load && !r_fault && !r_mis) ? w_ext : 32'd0;
        o_t_load_misaligned  = o_done && r_mis   && w_r_load;
        o_t_store_misaligned = o_done && r_mis   && w_r_store;
        o_t_load_fault       = o_done && r_fault && w_r_load;
        o_t_store_fault      = o_done && r_fault && w_r_store;

        dmem.o_dmem_req   = (r_state == S_REQ);
        dmem.o_dmem_we    = w_r_store;
        dmem.o_dmem_addr  = {r_addr[31:2], 2'b00};
        dmem.o_dmem_be    = r_be;
        dmem.o_dmem_wdata = r_wdata;
    end

    // State register, op latch, WAIT counter, kill bit and response capture.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
            r_op    <= LSU_NONE;
            r_addr  <= 32'd0;
            r_wdata <= 32'd0;
            r_rdata <= 32'd0;
            r_be    <= 4'd0;
            r_cnt   <= 8'd0;
            r_kill  <= 1'b0;
            r_mis   <= 1'b0;
            r_fault <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_ld) begin
                r_op    <= i_ls_op;
                r_addr  <= i_addr;
                r_be    <= w_be_in;
                r_wdata <= w_wd_in;
                r_mis   <= w_mis;
                r_fault <= 1'b0;
                r_rdata <= 32'd0;
            end
            if ((r_state == S_WAIT) && !w_end_wait) begin
                r_cnt <= r_cnt + 8'd1;
            end else begin
                r_cnt <= 8'd0;
            end
            if (w_set_kill) begin
                r_kill <= 1'b1;
            end else if (w_end_wait || w_ld) begin
                r_kill <= 1'b0;
            end
            if (w_end_wait) begin
                r_rdata <= dmem.i_dmem_rvalid ? dmem.i_dmem_rdata : 32'd0;
                r_fault <= w_timeout || (dmem.i_dmem_rvalid && dmem.i_dmem_err);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_lsu.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_lsu
//  Description : Directed self-checking bench for mem_lsu with an expected-
//                response queue popped at each completion.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mem_lsu;
    import cotm32_pkg::*;

    typedef struct packed {
        logic [31:0] rdata;
        logic [3:0]  flags;   // {ld_mis, st_mis, ld_fault, st_fault}
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid;
    ls_op_e      op;
    logic [31:0] addr, wdata;
    logic        flush;
    logic        stall, done;
    logic [31:0] rdata;
    logic        tlm, tsm, tlf, tsf;

    int   total = 0;
    int   bad   = 0;
    exp_t sb[$];

    mem_lsu_if bus ();

    mem_lsu #(.TIMEOUT_CYCLES(4)) dut (
        .i_clk               (clk),
        .i_rst_n             (rst_n),
        .i_valid             (valid),
        .i_ls_op             (op),
        .i_addr              (addr),
        .i_wdata             (wdata),
        .i_flush             (flush),
        .o_stall             (stall),
        .o_done              (done),
        .o_rdata             (rdata),
        .o_t_load_misaligned (tlm),
        .o_t_store_misaligned(tsm),
        .o_t_load_fault      (tlf),
        .o_t_store_fault     (tsf),
        .dmem                (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    task automatic pop_check(input string tag);
        exp_t e;
        chk({tag, ".done"}, {31'd0, done}, 32'd1);
        chk({tag, ".sb"}, {31'd0, (sb.size() != 0)}, 32'd1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk({tag, ".rdata"}, rdata, e.rdata);
            chk({tag, ".flags"}, {28'd0, tlm, tsm, tlf, tsf}, {28'd0, e.flags});
        end
    endtask

    task automatic idle_inputs();
        valid = 1'b0; op = LSU_NONE; flush = 1'b0;
        bus.i_dmem_gnt = 1'b0; bus.i_dmem_rvalid = 1'b0;
        bus.i_dmem_err = 1'b0; bus.i_dmem_rdata = 32'd0;
    endtask

    task automatic accept(input ls_op_e t_op, input logic [31:0] t_addr, input logic [31:0] t_wd);
        @(negedge clk);
        valid = 1'b1; op = t_op; addr = t_addr; wdata = t_wd;
        #1;
    endtask

    // Zero-wait access: accept N, gnt N+1, rvalid N+2, done N+3.
    task automatic zw(input string tag, input ls_op_e t_op, input logic [31:0] t_addr,
                      input logic [31:0] t_wd, input logic [31:0] t_bus_rd,
                      input logic [31:0] e_addr, input logic [3:0] e_be, input logic e_we,
                      input logic [31:0] e_wd, input logic [31:0] e_rd);
        sb.push_back({e_rd, 4'b0000});
        accept(t_op, t_addr, t_wd);
        chk({tag, ".acc_stall"}, {31'd0, stall}, 32'd1);
        chk({tag, ".acc_req"}, {31'd0, bus.o_dmem_req}, 32'd0);
        @(negedge clk); bus.i_dmem_gnt = 1'b1; #1;
        chk({tag, ".req"}, {31'd0, bus.o_dmem_req}, 32'd1);
        chk({tag, ".addr"}, bus.o_dmem_addr, e_addr);
        chk({tag, ".be"}, {28'd0, bus.o_dmem_be}, {28'd0, e_be});
        chk({tag, ".we"}, {31'd0, bus.o_dmem_we}, {31'd0, e_we});
        if (e_we) chk({tag, ".wdata"}, bus.o_dmem_wdata, e_wd);
        @(negedge clk);
        bus.i_dmem_gnt = 1'b0; bus.i_dmem_rvalid = 1'b1; bus.i_dmem_rdata = t_bus_rd; #1;
        chk({tag, ".wait_done"}, {31'd0, done}, 32'd0);
        @(negedge clk); bus.i_dmem_rvalid = 1'b0; #1;
        pop_check(tag);
        chk({tag, ".resp_stall"}, {31'd0, stall}, 32'd0);
        @(negedge clk); valid = 1'b0; op = LSU_NONE; #1;
        chk({tag, ".no_reaccept"}, {31'd0, bus.o_dmem_req}, 32'd0);
    endtask

    // Misaligned access: no bus request, done on the next cycle.
    task automatic mis(input string tag, input ls_op_e t_op, input logic [31:0] t_addr,
                       input logic [3:0] e_flags);
        sb.push_back({32'd0, e_flags});
        accept(t_op, t_addr, 32'h1234_5678);
        chk({tag, ".stall"}, {31'd0, stall}, 32'd1);
        @(negedge clk); #1;
        chk({tag, ".req"}, {31'd0, bus.o_dmem_req}, 32'd0);
        pop_check(tag);
        @(negedge clk); valid = 1'b0; op = LSU_NONE; #1;
    endtask

    initial begin
        idle_inputs();
        addr = 32'd0; wdata = 32'd0;
        rst_n = 1'b0;
        valid = 1'b1; op = LSU_LW;
        @(negedge clk); #1;
        chk("rst.stall", {31'd0, stall}, 32'd0);
        chk("rst.done", {31'd0, done}, 32'd0);
        chk("rst.req", {31'd0, bus.o_dmem_req}, 32'd0);
        chk("rst.rdata", rdata, 32'd0);
        @(negedge clk); idle_inputs(); rst_n = 1'b1;

        // Sign-extended byte load from the top lane.
        zw("lb", LSU_LB, 32'h1003, 32'd0, 32'h80FF_FF00, 32'h1000, 4'b1000, 1'b0, 32'd0, 32'hFFFF_FF80);
        zw("lh", LSU_LH, 32'h9002, 32'd0, 32'hF00D_1234, 32'h9000, 4'b1100, 1'b0, 32'd0, 32'hFFFF_F00D);
        zw("lbu", LSU_LBU, 32'h9001, 32'd0, 32'h0000_9C00, 32'h9000, 4'b0010, 1'b0, 32'd0, 32'h0000_009C);
        zw("sw", LSU_SW, 32'h6000, 32'hCAFE_F00D, 32'h1111_1111, 32'h6000, 4'b1111, 1'b1, 32'hCAFE_F00D, 32'd0);
        zw("sb", LSU_SB, 32'h8001, 32'h0000_00A5, 32'd0, 32'h8000, 4'b0010, 1'b1, 32'hA5A5_A5A5, 32'd0);

        // Halfword store; response arrives one cycle late.
        sb.push_back({32'd0, 4'b0000});
        accept(LSU_SH, 32'h2002, 32'h0000_BEEF);
        @(negedge clk); bus.i_dmem_gnt = 1'b1; #1;
        chk("sh.be", {28'd0, bus.o_dmem_be}, 32'hC);
        chk("sh.wdata", bus.o_dmem_wdata, 32'hBEEF_BEEF);
        chk("sh.we", {31'd0, bus.o_dmem_we}, 32'd1);
        @(negedge clk); bus.i_dmem_gnt = 1'b0; #1;
        chk("sh.wait_done", {31'd0, done}, 32'd0);
        @(negedge clk); bus.i_dmem_rvalid = 1'b1; #1;
        chk("sh.rv_stall", {31'd0, stall}, 32'd1);
        @(negedge clk); bus.i_dmem_rvalid = 1'b0; #1;
        pop_check("sh");
        @(negedge clk); idle_inputs(); #1;

        mis("lw_mis", LSU_LW, 32'h3001, 4'b1000);
        mis("lh_mis", LSU_LH, 32'h0001, 4'b1000);
        mis("sw_mis", LSU_SW, 32'h0002, 4'b0100);
        mis("sh_mis", LSU_SH, 32'h0003, 4'b0100);

        // LHU with grant delayed three cycles, response carries an error.
        sb.push_back({32'd0, 4'b0010});
        accept(LSU_LHU, 32'h4002, 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            chk("lhu.req_held", {31'd0, bus.o_dmem_req}, 32'd1);
            chk("lhu.req_stall", {31'd0, stall}, 32'd1);
        end
        @(negedge clk); bus.i_dmem_gnt = 1'b1; #1;
        @(negedge clk);
        bus.i_dmem_gnt = 1'b0; bus.i_dmem_rvalid = 1'b1; bus.i_dmem_err = 1'b1;
        bus.i_dmem_rdata = 32'h1234_5678; #1;
        chk("lhu.wait_stall", {31'd0, stall}, 32'd1);
        @(negedge clk); bus.i_dmem_rvalid = 1'b0; bus.i_dmem_err = 1'b0; #1;
        pop_check("lhu");
        @(negedge clk); idle_inputs(); #1;

        // Flush in WAIT, rvalid two cycles later: drained with no completion.
        accept(LSU_LW, 32'h5000, 32'd0);
        @(negedge clk); bus.i_dmem_gnt = 1'b1; #1;
        @(negedge clk); bus.i_dmem_gnt = 1'b0; valid = 1'b0; op = LSU_NONE; flush = 1'b1; #1;
        chk("fw.done0", {31'd0, done}, 32'd0);
        @(negedge clk); flush = 1'b0; #1;
        chk("fw.stall", {31'd0, stall}, 32'd1);
        @(negedge clk); bus.i_dmem_rvalid = 1'b1; bus.i_dmem_rdata = 32'hDEAD_BEEF; #1;
        chk("fw.done2", {31'd0, done}, 32'd0);
        @(negedge clk); bus.i_dmem_rvalid = 1'b0; #1;
        chk("fw.done3", {31'd0, done}, 32'd0);
        chk("fw.idle", {31'd0, stall}, 32'd0);
        zw("after_flush", LSU_LW, 32'h5004, 32'd0, 32'h0BAD_F00D, 32'h5004, 4'b1111, 1'b0, 32'd0, 32'h0BAD_F00D);

        // Timeout after four WAIT cycles with no response.
        sb.push_back({32'd0, 4'b0010});
        accept(LSU_LW, 32'h7000, 32'd0);
        @(negedge clk); bus.i_dmem_gnt = 1'b1; #1;
        @(negedge clk); bus.i_dmem_gnt = 1'b0; #1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            chk("to.wait_done", {31'd0, done}, 32'd0);
            chk("to.wait_stall", {31'd0, stall}, 32'd1);
        end
        @(negedge clk); #1;
        pop_check("to");
        @(negedge clk); idle_inputs(); #1;

        // Flush in RESP suppresses completion and traps.
        accept(LSU_LW, 32'h3002, 32'd0);
        @(negedge clk); valid = 1'b0; op = LSU_NONE; flush = 1'b1; #1;
        chk("fresp.done", {31'd0, done}, 32'd0);
        chk("fresp.tlm", {31'd0, tlm}, 32'd0);
        @(negedge clk); flush = 1'b0; #1;

        // Flush in REQ before grant drops the request.
        accept(LSU_LW, 32'hA000, 32'd0);
        @(negedge clk); valid = 1'b0; op = LSU_NONE; flush = 1'b1; #1;
        chk("freq.req", {31'd0, bus.o_dmem_req}, 32'd1);
        @(negedge clk); flush = 1'b0; #1;
        chk("freq.dropped", {31'd0, bus.o_dmem_req}, 32'd0);
        chk("freq.stall", {31'd0, stall}, 32'd0);
        @(negedge clk); #1;
        chk("freq.done", {31'd0, done}, 32'd0);

        // Reset mid-REQ clears the request asynchronously.
        accept(LSU_LW, 32'hB000, 32'd0);
        @(negedge clk); valid = 1'b0; op = LSU_NONE; #1;
        rst_n = 1'b0; #1;
        chk("rreq.req", {31'd0, bus.o_dmem_req}, 32'd0);
        @(negedge clk); rst_n = 1'b1; #1;

        // Reset mid-WAIT; a late rvalid afterwards is ignored.
        accept(LSU_LW, 32'hC000, 32'd0);
        @(negedge clk); bus.i_dmem_gnt = 1'b1; #1;
        @(negedge clk); bus.i_dmem_gnt = 1'b0; valid = 1'b0; op = LSU_NONE; #1;
        rst_n = 1'b0; #1;
        chk("rwait.stall", {31'd0, stall}, 32'd0);
        @(negedge clk); rst_n = 1'b1; bus.i_dmem_rvalid = 1'b1; #1;
        chk("rwait.late_done", {31'd0, done}, 32'd0);
        @(negedge clk); bus.i_dmem_rvalid = 1'b0; #1;
        chk("rwait.done", {31'd0, done}, 32'd0);
        chk("rwait.idle", {31'd0, stall}, 32'd0);

        chk("sb.empty", sb.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_lsu.md
MEM_LSU -- requirements
Module: mem_lsu

Interface
REQ-001 The module SHALL have parameter TIMEOUT_CYCLES, default 255, giving the maximum WAIT cycles before an access fault is declared (range 1..255).
REQ-002 The module SHALL have port i_clk  in  1  sole clock; all state updates on its rising edge.
REQ-003 The module SHALL have port i_rst_n  in  1  asynchronous, active-low reset.
REQ-004 The module SHALL have port i_valid  in  1  EX/MEM entry valid.
REQ-005 The module SHALL have port i_ls_op  in  lsu op type  LSU_NONE/LB/LH/LW/LBU/LHU/SB/SH/SW, from cotm32_pkg.
REQ-006 The module SHALL have port i_addr  in  32  effective byte address.
REQ-007 The module SHALL have port i_wdata  in  32  store data, low-aligned.
REQ-008 The module SHALL have port i_flush  in  1  kill the in-flight op.
REQ-009 The module SHALL have port o_stall  out  1  hold EX/MEM and all upstream stages.
REQ-010 The module SHALL have port o_done  out  1  one-cycle completion pulse.
REQ-011 The module SHALL have port o_rdata  out  32  extended load result, valid with o_done.
REQ-012 The module SHALL have ports o_t_load_misaligned, o_t_store_misaligned, o_t_load_fault and o_t_store_fault, each  out  1  trap flags, valid with o_done.
REQ-013 The module SHALL have ports o_dmem_req out 1, o_dmem_we out 1, o_dmem_addr out 32 (bits[1:0]=0), o_dmem_be out 4, o_dmem_wdata out 32.
REQ-014 The module SHALL have ports i_dmem_gnt in 1, i_dmem_rvalid in 1, i_dmem_rdata in 32, i_dmem_err in 1.

Function
REQ-015 The FSM SHALL have states IDLE, REQ, WAIT, RESP.
REQ-016 A mem op SHALL be i_valid=1 with i_ls_op!=LSU_NONE; misaligned SHALL mean halfword with addr[0]=1, or word with addr[1:0]!=0.
REQ-017 In IDLE with an aligned mem op, the FSM SHALL latch op, addr, be and wdata, and move to REQ.
REQ-018 In IDLE with a misaligned mem op, the FSM SHALL go to RESP with the matching misaligned flag set and no bus request.
REQ-019 In IDLE with no mem op, the FSM SHALL stay in IDLE and hold o_stall=0.
REQ-020 In REQ, o_dmem_req SHALL be 1 with stable addr/we/be/wdata; on i_dmem_gnt the FSM SHALL go to WAIT.
REQ-021 In WAIT, the FSM SHALL go to RESP on i_dmem_rvalid, capturing rdata; i_dmem_err with rvalid SHALL set the load or store fault flag.
REQ-022 An 8-bit WAIT counter SHALL force RESP with the fault flag once it reaches TIMEOUT_CYCLES without rvalid.
REQ-023 In RESP, o_done SHALL be 1 for exactly one cycle, after which the FSM SHALL return to IDLE; an op present in RESP SHALL NOT be re-accepted.
REQ-024 o_stall SHALL be 1 in IDLE while accepting an op, and in REQ and WAIT; it SHALL be 0 in RESP.
REQ-025 Minimum latency SHALL be accept cycle N, gnt at N+1, rvalid at N+2, o_done at N+3; stores SHALL also wait for rvalid.
REQ-026 Byte enables SHALL be: SB -> 1<<addr[1:0]; SH -> addr[1] ? 4'b1100 : 4'b0011; SW -> 4'b1111.
REQ-027 Store data SHALL be replicated: bytes x4 for SB, halves x2 for SH.
REQ-028 Loads SHALL select the lane by addr[1:0]; LB/LH SHALL sign-extend, LBU/LHU SHALL zero-extend; o_rdata SHALL be 0 for stores and faults.
REQ-029 i_flush in REQ before gnt SHALL drop the request and return the FSM to IDLE with no o_done.
REQ-030 i_flush coinciding with gnt, or in WAIT, SHALL set a kill bit; the FSM SHALL wait for rvalid or timeout, then go to IDLE with no o_done.
REQ-031 i_flush in RESP SHALL suppress o_done and all trap flags.
REQ-032 Simultaneous gnt and rvalid SHALL be illegal; rvalid is sampled only in WAIT.

Reset
REQ-033 While i_rst_n=0, the FSM SHALL be IDLE and all outputs, the counter and the kill bit SHALL be 0, asynchronously.
REQ-034 Reset asserted mid-REQ or mid-WAIT SHALL abandon the op with no o_done; a late rvalid after reset SHALL be ignored.

Verification
REQ-035 The bench SHALL cover LB addr=0x1003, rdata=0x80FF_FF00, zero-wait -> o_dmem_addr=0x1000, be=1000, o_done at N+3, o_rdata=0xFFFFFF80.
REQ-036 The bench SHALL cover SH addr=0x2002, wdata=0x0000_BEEF -> be=1100, o_dmem_wdata=0xBEEFBEEF, we=1, o_done after rvalid.
REQ-037 The bench SHALL cover LW addr=0x3001 -> no o_dmem_req, o_done at N+1, o_t_load_misaligned=1.
REQ-038 The bench SHALL cover LHU with gnt delayed 3 cycles and rvalid+err -> o_stall held through WAIT, o_t_load_fault=1, o_rdata=0.
REQ-039 The bench SHALL cover flush in WAIT, then rvalid 2 cycles later -> no o_done, FSM returns to IDLE, next op accepted.
REQ-040 The bench SHALL cover TIMEOUT_CYCLES=4 with no rvalid -> RESP after 4 WAIT cycles with the fault flag set.
